// File: rtl/moddiv_pkg.sv
// Shared constants for the moddiv operand path: select encoding, operand
// count and width, plus the loader FSM state type.
package moddiv_pkg;

  localparam int OPERAND_W  = 16;
  localparam int N_OPERANDS = 6;

  localparam logic [2:0] SEL_A = 3'd0;
  localparam logic [2:0] SEL_B = 3'd1;
  localparam logic [2:0] SEL_C = 3'd2;
  localparam logic [2:0] SEL_D = 3'd3;
  localparam logic [2:0] SEL_E = 3'd4;
  localparam logic [2:0] SEL_F = 3'd5;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } loader_state_t;

endpackage

// File: rtl/demux16_6_loader_seq_idx_ctr.sv
// Modulo-6 slot index for sequential loading. It wraps F -> A and has a
// synchronous clear that takes priority over the enable.
module seq_idx_ctr
  import moddiv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] idx
);

  logic [2:0] idx_reg;

  // Index register: clear wins, otherwise step with wrap after the last slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= SEL_A;
    end else if (clr) begin
      idx_reg <= SEL_A;
    end else if (en) begin
      idx_reg <= (idx_reg == SEL_F) ? SEL_A : idx_reg + 3'd1;
    end
  end

  assign idx = idx_reg;

endmodule

// File: rtl/demux16_6_loader.sv
// Write-side loader for the 6:1 operand mux. Words arriving on a valid/ready
// stream are steered into holding registers a..f, either by in_sel or by an
// internal running index. Once all six slots are written, the bank is held
// until the consumer acknowledges it.
module demux16_6_loader
  import moddiv_pkg::*;
#(
  parameter int W = OPERAND_W,
  parameter int N = N_OPERANDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [2:0]   in_sel,
  input  logic         out_ack,
  output logic         out_valid,
  output logic         err_sel,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic [W-1:0] e,
  output logic [W-1:0] f,
  output logic [N-1:0] load_mask
);

  loader_state_t state_reg, state_next;
  logic [N-1:0]  mask_reg, mask_next;
  logic [W-1:0]  bank_reg [N];
  logic          err_sel_reg;
  logic [2:0]    seq_idx;
  logic [2:0]    tgt;
  logic          bad_sel;
  logic          xfer;
  logic          bank_release;
  logic [N-1:0]  wr_onehot;

  // Ready only while loading. It is gated by reset so that nothing is
  // accepted while rst_n is low, and by clr so that a word offered during a
  // clear is visibly dropped.
  assign in_ready     = rst_n & (state_reg == LOAD) & ~clr;
  assign xfer         = in_valid & in_ready;
  assign bank_release = (state_reg == FULL) & out_ack & ~clr;

  // Slot decode: sequential mode ignores in_sel; selects 6 and 7 are invalid
  // only in addressed mode.
  always_comb begin
    tgt     = mode ? seq_idx : in_sel;
    bad_sel = ~mode & (in_sel > SEL_F);
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      assign wr_onehot[gi] = xfer & ~bad_sel & (tgt == 3'(gi));

      // One holding register per slot. It is zeroed by clr, loaded on its
      // write strobe, and otherwise holds its value across bank releases.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bank_reg[gi] <= '0;
        end else if (clr) begin
          bank_reg[gi] <= '0;
        end else if (wr_onehot[gi]) begin
          bank_reg[gi] <= in_data;
        end
      end
    end
  endgenerate

  seq_idx_ctr u_seq_idx_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr | bank_release),
    .en    (xfer & mode),
    .idx   (seq_idx)
  );

  // Next-state and next-mask logic. clr overrides everything; the bank
  // becomes FULL on the transfer that completes the mask.
  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg | wr_onehot;
    if (clr) begin
      state_next = LOAD;
      mask_next  = '0;
    end else begin
      case (state_reg)
        LOAD: begin
          if ((mask_reg | wr_onehot) == {N{1'b1}}) begin
            state_next = FULL;
          end
        end
        FULL: begin
          if (out_ack) begin
            state_next = LOAD;
            mask_next  = '0;
          end
        end
        default: state_next = LOAD;
      endcase
    end
  end

  // State and mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LOAD;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
    end
  end

  // Sticky bad-select flag. Only reset clears it; clr does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel_reg <= 1'b0;
    end else if (xfer & bad_sel) begin
      err_sel_reg <= 1'b1;
    end
  end

  assign out_valid = (state_reg == FULL);
  assign err_sel   = err_sel_reg;
  assign load_mask = mask_reg;
  assign a = bank_reg[SEL_A];
  assign b = bank_reg[SEL_B];
  assign c = bank_reg[SEL_C];
  assign d = bank_reg[SEL_D];
  assign e = bank_reg[SEL_E];
  assign f = bank_reg[SEL_F];

endmodule
